// File: rtl/cbus_arbiter.sv
// Round-robin arbiter that shares one CBus among NUM_REQ requesters.
// A grant is held for a whole burst and released on the ready && last beat.
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

// Per-requester response gate: only the granted lane sees the memory response.
module cbus_arb_lane
  import cbus_pkg::*;
(
  input  logic       gnt,
  input  cbus_resp_t src,
  output cbus_resp_t lane_resp
);
  assign lane_resp = gnt ? src : '0;
endmodule

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  cbus_req_t  [NUM_REQ-1:0]  ireqs,
  output cbus_resp_t [NUM_REQ-1:0]  oresps,
  output cbus_req_t                 oreq,
  input  cbus_resp_t                oresp
);
  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [SW-1:0]   sel, ptr, pick, sel_nxt;
  logic            any;
  logic [NUM_REQ-1:0] gnt;
  int              idx;

  // Scan offsets from farthest to nearest so the first valid at/after ptr wins.
  always_comb begin
    any  = 1'b0;
    pick = ptr;
    idx  = 0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (ireqs[idx].valid) begin
        any  = 1'b1;
        pick = SW'(idx);
      end
    end
  end

  assign sel_nxt = (sel == SW'(NUM_REQ-1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          sel   <= pick;
          state <= BUSY;
        end
        BUSY: if (oresp.ready && oresp.last) begin
          state <= IDLE;
          ptr   <= sel_nxt;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request path depends only on registered state/sel, never on oresp.
  assign oreq = (state == BUSY) ? ireqs[sel] : '0;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    assign gnt[k] = (state == BUSY) && (sel == SW'(k));
    cbus_arb_lane u_lane (
      .gnt       (gnt[k]),
      .src       (oresp),
      .lane_resp (oresps[k])
    );
  end
endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: a 2-requester and a 3-requester instance,
// a small memory responder, and a grant-order scoreboard.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cbus_req_t  [1:0] ireqs;
  cbus_resp_t [1:0] oresps;
  cbus_req_t        oreq;
  cbus_resp_t       oresp;

  cbus_req_t  [2:0] ireqs3;
  cbus_resp_t [2:0] oresps3;
  cbus_req_t        oreq3;
  cbus_resp_t       oresp3;

  cbus_arbiter #(.NUM_REQ(2)) dut (
    .clk(clk), .reset(reset), .ireqs(ireqs), .oresps(oresps), .oreq(oreq), .oresp(oresp)
  );
  cbus_arbiter #(.NUM_REQ(3)) dut3 (
    .clk(clk), .reset(reset), .ireqs(ireqs3), .oresps(oresps3), .oreq(oreq3), .oresp(oresp3)
  );

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int exp_q[$];
  int got_q[$];
  int got_cyc[$];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic cbus_req_t mkreq(input int k, input int len);
    cbus_req_t r;
    r.valid = 1'b1;
    r.write = k[0];
    r.addr  = 32'h100 + 32'(k);
    r.wdata = 32'(k * 3 + 7);
    r.len   = 4'(len);
    return r;
  endfunction

  task automatic do_reset;
    ireqs  = '0; oresp  = '0;
    ireqs3 = '0; oresp3 = '0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  // Memory responder for the 2-requester DUT; records grant order and start cycle.
  task automatic run_mem(input int ntxn, input int wt, input int budget);
    int done = 0, beat = 0, w = 0, nb = 0, n = 0;
    bit act = 1'b0;
    while (done < ntxn && n < budget) begin
      @(posedge clk); #1;
      n++;
      oresp = '0;
      if (oreq.valid) begin
        if (!act) begin
          act = 1'b1;
          got_q.push_back(int'(oreq.addr[7:0]));
          got_cyc.push_back(cyc_n);
          beat = 0; w = 0; nb = int'(oreq.len) + 1;
        end
        if (w < wt) w++;
        else begin
          oresp.ready = 1'b1;
          oresp.data  = $urandom;
          beat++;
          if (beat == nb) begin
            oresp.last = 1'b1;
            act = 1'b0;
            done++;
          end
        end
      end
    end
    @(posedge clk); #1;
    oresp = '0;
  endtask

  task automatic test_reset;
    ireqs = '0; oresp = '0; ireqs3 = '0; oresp3 = '0;
    reset = 1'b1;
    ireqs[0] = mkreq(0, 0);
    @(negedge clk);
    total++;
    if (oreq !== '0) begin bad++; $display("FAIL reset_oreq got=%h exp=0", oreq); end
    total++;
    if (oresps !== '0) begin bad++; $display("FAIL reset_oresps got=%h exp=0", oresps); end
    total++;
    if (dut.ptr !== 1'b0) begin bad++; $display("FAIL reset_ptr got=%0d exp=0", dut.ptr); end
    do_reset();
  endtask

  task automatic test_single;
    do_reset();
    ireqs[1] = mkreq(1, 0);                 // cycle 0
    @(negedge clk);
    total++;
    if (oreq.valid !== 1'b0) begin bad++; $display("FAIL single_c0_valid got=%b exp=0", oreq.valid); end
    @(posedge clk); #1;                     // cycle 1
    @(negedge clk);
    total++;
    if (oreq !== mkreq(1, 0)) begin bad++; $display("FAIL single_c1_oreq got=%h exp=%h", oreq, mkreq(1, 0)); end
    @(posedge clk); #1;                     // cycle 2
    @(posedge clk); #1;                     // cycle 3
    oresp = '{ready: 1'b1, last: 1'b1, data: 32'hDEAD_BEEF};
    @(negedge clk);
    total++;
    if (oresps[1] !== oresp) begin bad++; $display("FAIL single_c3_resp1 got=%h exp=%h", oresps[1], oresp); end
    total++;
    if (oresps[0] !== '0) begin bad++; $display("FAIL single_c3_resp0 got=%h exp=0", oresps[0]); end
    @(posedge clk); #1;                     // cycle 4
    oresp = '0; ireqs = '0;
    @(negedge clk);
    total++;
    if (oreq.valid !== 1'b0) begin bad++; $display("FAIL single_c4_valid got=%b exp=0", oreq.valid); end
    total++;
    if (dut.ptr !== 1'b0) begin bad++; $display("FAIL single_ptr got=%0d exp=0", dut.ptr); end
  endtask

  task automatic test_contention;
    int e, g;
    do_reset();
    ireqs[0] = mkreq(0, 0);
    ireqs[1] = mkreq(1, 0);
    for (int r = 0; r < 3; r++) begin exp_q.push_back(0); exp_q.push_back(1); end
    run_mem(6, 0, 200);
    ireqs = '0;
    total++;
    if (got_q.size() != 6) begin bad++; $display("FAIL contention_count got=%0d exp=6", got_q.size()); end
    for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL contention_grant%0d got=%0d exp=%0d", i, g, e); end
    end
    for (int i = 1; i < got_cyc.size(); i++) begin
      total++;
      if (got_cyc[i] - got_cyc[i-1] != 2)
        begin bad++; $display("FAIL contention_gap%0d got=%0d exp=2", i, got_cyc[i] - got_cyc[i-1]); end
    end
  endtask

  task automatic test_burst;
    int e, g;
    do_reset();
    ireqs[0] = mkreq(0, 3);
    ireqs[1] = mkreq(1, 0);
    exp_q.push_back(0); exp_q.push_back(1);
    run_mem(2, 0, 200);
    ireqs = '0;
    total++;
    if (got_q.size() != 2) begin bad++; $display("FAIL burst_count got=%0d exp=2", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL burst_grant got=%0d exp=%0d", g, e); end
    end
    if (got_cyc.size() == 2) begin
      total++;
      // four beats (first..first+3), one idle cycle, then the next grant
      if (got_cyc[1] - got_cyc[0] != 5)
        begin bad++; $display("FAIL burst_switch got=%0d exp=5", got_cyc[1] - got_cyc[0]); end
    end
  endtask

  task automatic test_wait;
    do_reset();
    ireqs[0] = mkreq(0, 0);
    ireqs[1] = mkreq(1, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      oresp = '{ready: 1'b0, last: (i == 2), data: $urandom};
      @(negedge clk);
      total++;
      if (oresps[0] !== oresp) begin bad++; $display("FAIL wait%0d_resp0 got=%h exp=%h", i, oresps[0], oresp); end
      total++;
      if (oresps[1] !== '0) begin bad++; $display("FAIL wait%0d_resp1 got=%h exp=0", i, oresps[1]); end
      total++;
      if (oreq !== mkreq(0, 0)) begin bad++; $display("FAIL wait%0d_oreq got=%h exp=%h", i, oreq, mkreq(0, 0)); end
    end
    @(posedge clk); #1;
    oresp = '{ready: 1'b1, last: 1'b1, data: 32'h1234_5678};
    @(negedge clk);
    total++;
    if (oresps[0] !== oresp) begin bad++; $display("FAIL wait_final_resp0 got=%h exp=%h", oresps[0], oresp); end
    @(posedge clk); #1;
    oresp = '0; ireqs = '0;
    @(negedge clk);
    total++;
    if (oreq.valid !== 1'b0) begin bad++; $display("FAIL wait_release got=%b exp=0", oreq.valid); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    ireqs[0] = mkreq(0, 0);
    run_mem(1, 0, 50);
    ireqs = '0;
    total++;
    if (dut.ptr !== 1'b1) begin bad++; $display("FAIL rmid_pre_ptr got=%0d exp=1", dut.ptr); end
    ireqs[1] = mkreq(1, 3);
    @(posedge clk); #1;                     // grant visible from here
    oresp = '{ready: 1'b1, last: 1'b0, data: 32'h11};
    @(posedge clk); #1;
    oresp = '{ready: 1'b1, last: 1'b0, data: 32'h22};
    #1 reset = 1'b1;
    #1;
    total++;
    if (oreq.valid !== 1'b0) begin bad++; $display("FAIL rmid_oreq got=%b exp=0", oreq.valid); end
    total++;
    if (oresps !== '0) begin bad++; $display("FAIL rmid_oresps got=%h exp=0", oresps); end
    total++;
    if (dut.ptr !== 1'b0) begin bad++; $display("FAIL rmid_ptr got=%0d exp=0", dut.ptr); end
    @(posedge clk); #1;
    reset = 1'b0;
    oresp = '0;
    ireqs[1] = mkreq(1, 0);
    @(negedge clk);
    total++;
    if (oreq.valid !== 1'b0) begin bad++; $display("FAIL rmid_idle got=%b exp=0", oreq.valid); end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (oreq !== mkreq(1, 0)) begin bad++; $display("FAIL rmid_regrant got=%h exp=%h", oreq, mkreq(1, 0)); end
    oresp = '{ready: 1'b1, last: 1'b1, data: 32'h33};
    @(posedge clk); #1;
    oresp = '0; ireqs = '0;
  endtask

  task automatic test_three;
    int prev = -1, n = 0, guard = 0, id, e, g;
    do_reset();
    for (int k = 0; k < 3; k++) ireqs3[k] = mkreq(k, 0);
    exp_q = '{0, 1, 2, 0, 1};
    while (n < 5 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
      oresp3 = '0;
      if (oreq3.valid) begin
        id = int'(oreq3.addr[7:0]);
        got_q.push_back(id);
        oresp3 = '{ready: 1'b1, last: 1'b1, data: 32'(id)};
        prev = id;
        n++;
      end else if (prev >= 0) begin
        @(negedge clk);
        total++;
        if (dut3.ptr !== 2'((prev + 1) % 3))
          begin bad++; $display("FAIL three_ptr_after%0d got=%0d exp=%0d", prev, dut3.ptr, (prev + 1) % 3); end
      end
    end
    @(posedge clk); #1;
    oresp3 = '0; ireqs3 = '0;
    total++;
    if (got_q.size() != 5) begin bad++; $display("FAIL three_count got=%0d exp=5", got_q.size()); end
    for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL three_grant%0d got=%0d exp=%0d", i, g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_burst();
    test_wait();
    test_reset_mid();
    test_three();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 2, number of CBus requesters sharing one CBus (range 2..8).
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: ireqs  input  cbus_req_t[NUM_REQ]  per-requester CBus requests; index 0 = instruction side, 1 = data side.
REQ-005 Port: oresps  output  cbus_resp_t[NUM_REQ]  per-requester CBus responses.
REQ-006 Port: oreq  output  cbus_req_t  request to the shared CBus/memory.
REQ-007 Port: oresp  input  cbus_resp_t  response from the shared CBus/memory (ready, last, data).

Function
REQ-008 Two-state FSM: IDLE (no grant held), BUSY (grant held by index sel).
REQ-009 Registered state: state, sel (clog2(NUM_REQ) bits), ptr (round-robin pointer, same width).
REQ-010 IDLE: oreq all-zero (valid=0); every oresps[k] all-zero.
REQ-011 IDLE with >=1 ireqs[k].valid: sel <= first valid index searching ptr, ptr+1, ... wrapping modulo NUM_REQ; state <= BUSY next edge.
REQ-012 IDLE with no valid request: state, sel, ptr unchanged.
REQ-013 Grant latency: one cycle from a valid request seen in IDLE to oreq.valid asserted.
REQ-014 BUSY: oreq = ireqs[sel] unmodified (all fields, combinational passthrough).
REQ-015 BUSY: oresps[sel] = oresp unmodified; oresps[k] all-zero for k != sel.
REQ-016 BUSY: oresp.ready && oresp.last -> state <= IDLE, ptr <= (sel+1) mod NUM_REQ; sel held.
REQ-017 BUSY: oresp.ready && !oresp.last (burst beat) -> stay BUSY; no re-arbitration mid-burst.
REQ-018 BUSY: oresp.last without oresp.ready -> ignored; stay BUSY.
REQ-019 Requesters hold valid and all request fields stable until last-beat ready; arbiter does not abort if ireqs[sel].valid drops, stays BUSY until ready&&last.
REQ-020 Requests from non-selected requesters during BUSY: not forwarded, no response, wait.
REQ-021 After a completed transaction, IDLE lasts exactly one cycle before the next grant (IDLE -> BUSY -> IDLE -> BUSY); no back-to-back grant bypass.
REQ-022 Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...
REQ-023 Simultaneous: multiple valid in same IDLE cycle -> only the ptr-order winner granted; others unaffected.
REQ-024 Pointer wrap: sel = NUM_REQ-1 completing -> ptr <= 0.
REQ-025 No combinational path from oresp to oreq; combinational paths ireqs->oreq and oresp->oresps only via registered sel.

Reset
REQ-026 reset asserted: state <= IDLE, sel <= 0, ptr <= 0 immediately, without waiting for clk.
REQ-027 During and after reset: oreq.valid = 0, all oresps all-zero, until a new grant.
REQ-028 Reset mid-burst: transaction dropped; no further beats forwarded; outstanding memory transaction not tracked (memory side reset by same signal).

Verification
REQ-029 Single requester: ireqs[1] read, len 0, valid at cycle 0 -> oreq.valid=1 at cycle 1; oresp ready+last at cycle 3 -> oresps[1].ready/last=1 at cycle 3, oreq.valid=0 at cycle 4, ptr=0.
REQ-030 Contention: ireqs[0],ireqs[1] valid from cycle 0, ptr=0 -> 0 granted first; after its last beat, 1 granted next; then 0 again (alternation for 3 rounds).
REQ-031 Burst: ireqs[0] len 3 (4 beats), ready on 4 consecutive cycles, last on 4th; ireqs[1] valid throughout -> no switch until 4th beat; ireqs[1] granted 2 cycles after last beat.
REQ-032 Wait states: ready low for 5 cycles then ready+last -> oresps[sel] mirrors each cycle; other oresps stay zero; last without ready ignored.
REQ-033 Reset mid-burst: reset at beat 2 of 4 -> oreq.valid=0 same cycle, state IDLE, ptr=0; after reset release, ireqs[1] valid -> granted one cycle later.
REQ-034 NUM_REQ=3, all valid continuously -> grant order 0,1,2,0,1 with pointer wrap observed.
